// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle for regfile_wb_arbiter: ALU/LSU result inputs, register
// file write port, queue occupancy and decode bypass lookup.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 2
);
    logic                     alu_valid;
    logic [4:0]               alu_rd;
    logic [31:0]              alu_data;
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [4:0]               lsu_rd;
    logic [31:0]              lsu_data;
    logic                     reg_write;
    logic [4:0]               write_reg;
    logic [31:0]              write_data;
    logic [$clog2(DEPTH):0]   q_count;
    logic [4:0]               fwd_rs1;
    logic [4:0]               fwd_rs2;
    logic                     fwd_hit1;
    logic                     fwd_hit2;
    logic [31:0]              fwd_data1;
    logic [31:0]              fwd_data2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output fwd_rs1, fwd_rs2,
        input  lsu_ready, reg_write, write_reg, write_data, q_count,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  fwd_rs1, fwd_rs2,
        output lsu_ready, reg_write, write_reg, write_data, q_count,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results and queued load results onto the single register file write
// port. Define WB_BYPASS_EN to build the decode bypass from in-flight writes.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          reg_write_q;
    logic [4:0]    write_reg_q;
    logic [31:0]   write_data_q;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready comes from the registered count only, so a full queue refuses even
    // when the same cycle pops.
    assign bus.lsu_ready  = (count < CW'(DEPTH));
    assign push           = bus.lsu_valid && bus.lsu_ready;
    assign pop            = !bus.alu_valid && (count != '0);
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.q_count    = count;

    // NOTE: queue storage carries no reset; count and pointers alone decide which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= bus.lsu_rd;
            q_data[wr_ptr] <= bus.lsu_data;
        end
    end

    // NOTE: all state updates are non-blocking so every read in this block sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bus.alu_valid) begin
                reg_write_q  <= (bus.alu_rd != '0);
                write_reg_q  <= bus.alu_rd;
                write_data_q <= bus.alu_data;
            end else if (pop) begin
                reg_write_q  <= (q_rd[rd_ptr] != '0);
                write_reg_q  <= q_rd[rd_ptr];
                write_data_q <= q_data[rd_ptr];
            end else begin
                reg_write_q  <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Scans oldest to youngest so later (younger) matches override earlier ones;
    // the output stage is seeded first as the lowest-priority candidate.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rs);
        logic [32:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        if (rs != '0) begin
            if (reg_write_q && (write_reg_q == rs)) res = {1'b1, write_data_q};
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if ((CW'(k) < count) && (q_rd[idx] == rs)) res = {1'b1, q_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.fwd_rs1);
        {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.fwd_rs2);
    end
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^{bus.fwd_rs1, bus.fwd_rs2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a behavioural queue model predicts each
// cycle's write port, occupancy, ready and bypass values.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    wr_t  exp_q[$];
    ld_t  mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_d  = '0;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        if (rs == '0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == rs) return {1'b1, mq[i].d};
        if (m_we && m_rd == rs) return {1'b1, m_d};
        return '0;
`else
        return {1'b0, 27'd0, rs} & 33'd0;
`endif
    endfunction

    // One clock: predict from current inputs, advance, then compare after the edge.
    task automatic tick();
        logic ready_m, push_m, pop_m;
        ld_t  h;
        wr_t  e;
        ready_m = (mq.size() < DEPTH);
        if (!rst) check("lsu_ready", 64'(bus.lsu_ready), 64'(ready_m));
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_rd = '0; m_d = '0;
        end else begin
            push_m = bus.lsu_valid && ready_m;
            pop_m  = !bus.alu_valid && (mq.size() != 0);
            if (bus.alu_valid) begin
                m_we = (bus.alu_rd != '0); m_rd = bus.alu_rd; m_d = bus.alu_data;
            end else if (pop_m) begin
                h = mq.pop_front();
                m_we = (h.rd != '0); m_rd = h.rd; m_d = h.d;
            end else begin
                m_we = 1'b0;
            end
            if (push_m) mq.push_back('{rd: bus.lsu_rd, d: bus.lsu_data});
        end
        exp_q.push_back('{we: m_we, rd: m_rd, d: m_d});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("reg_write",  64'(bus.reg_write),  64'(e.we));
        check("write_reg",  64'(bus.write_reg),  64'(e.rd));
        check("write_data", 64'(bus.write_data), 64'(e.d));
        check("q_count",    64'(bus.q_count),    64'(mq.size()));
        check("fwd1", 64'({bus.fwd_hit1, bus.fwd_data1}), 64'(model_fwd(bus.fwd_rs1)));
        check("fwd2", 64'({bus.fwd_hit2, bus.fwd_data2}), 64'(model_fwd(bus.fwd_rs2)));
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_data = ld;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bus.fwd_rs1 = 5'd0;
        bus.fwd_rs2 = 5'd0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // ALU path: one-cycle latency, then write enable drops.
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        check("alu_wr_reg", 64'(bus.write_reg), 64'd5);
        check("alu_wr_data", 64'(bus.write_data), 64'h1234);
        idle(1);

        // Fill under continuous ALU traffic, then observe backpressure and drain.
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd6, 32'hA);
        drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd7, 32'hB);
        check("full_count", 64'(bus.q_count), 64'd2);
        check("full_ready", 64'(bus.lsu_ready), 64'd0);
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd8, 32'hC);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hD);
        check("drain_first", 64'(bus.write_data), 64'hA);
        idle(3);

        // Simultaneous push/pop across pointer wrap.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h50);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(11 + i), 32'h51 + 32'(i));
            check("pp_count", 64'(bus.q_count), 64'd1);
        end
        idle(2);

        // x0 destinations from both sources are consumed without a write.
        drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h55);
        idle(2);
        check("x0_count", 64'(bus.q_count), 64'd0);

        // Bypass: two queued writes to x3, younger wins; output stage on port 2.
        bus.fwd_rs1 = 5'd3;
        bus.fwd_rs2 = 5'd0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h11);
        drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd3, 32'h22);
`ifdef WB_BYPASS_EN
        check("byp_young", 64'({bus.fwd_hit1, bus.fwd_data1}), {31'd0, 1'b1, 32'h22});
`else
        check("byp_off", 64'(bus.fwd_hit1), 64'd0);
`endif
        bus.fwd_rs2 = 5'd4;
        drive(1'b1, 5'd4, 32'h46, 1'b0, 5'd0, 32'd0);

        // Mid-operation reset with a full queue.
        check("pre_rst_count", 64'(bus.q_count), 64'd2);
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h99);
        rst = 1'b0;
        check("rst_ready", 64'(bus.lsu_ready), 64'd1);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.fwd_rs1 = 5'($urandom_range(0, 7));
            bus.fwd_rs2 = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
